hazard_unit: RTL and testbench

Pipeline control block that drives the write/bubble side of the ID/EX register and its neighbours.
- Observes ID-stage source registers and the destination/control fields already latched in ID/EX and EX/MEM.
- Detects load-use and branch-operand hazards, freezes the pipeline during data-memory wait states, and flushes IF/ID on taken branches and jumps.
- Sits beside the ID stage; its outputs gate PC, IF/ID, ID/EX and EX/MEM updates.

---
 rtl/hazard_unit_pkg.sv | 33 +++
 rtl/hazard_cmp.sv | 20 ++
 rtl/hazard_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the ID-stage hazard/freeze controller.
package hazard_unit_pkg;

    localparam int unsigned DEF_REG_W = 5;
    localparam int unsigned ZERO_REG  = 0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hazState_e;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic ifidFlush;
        logic idexWrite;
        logic idexBubble;
        logic exmemWrite;
        logic memwbBubble;
    } pipeCtrl_t;

    localparam pipeCtrl_t CTRL_FLOW = '{
        pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0, idexWrite: 1'b1,
        idexBubble: 1'b0, exmemWrite: 1'b1, memwbBubble: 1'b0
    };

    localparam pipeCtrl_t CTRL_FREEZE = '{
        pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0, idexWrite: 1'b0,
        idexBubble: 1'b0, exmemWrite: 1'b0, memwbBubble: 1'b1
    };

endpackage

// File: rtl/hazard_cmp.sv
// Destination-vs-ID-source matcher; destination register 0 never matches.
module hazard_cmp
    import hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic             en,
    input  logic [REG_W-1:0] dst,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             usesRt,
    output logic             hit_c
);

    logic dstLive;

    assign dstLive = (dst != REG_W'(ZERO_REG));
    assign hit_c   = en && dstLive && ((dst == rs) || (usesRt && (dst == rt)));

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-operand stall, memory-wait freeze and branch/jump flush control.
// Optional HAZARD_PERF_EN adds saturating stall/freeze/flush cycle counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned REG_W       = DEF_REG_W,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_RegRs,
    input  logic [REG_W-1:0] ID_RegRt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_Jump,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [REG_W-1:0] EX_RegDst,
    input  logic             MEM_MemRead,
    input  logic [REG_W-1:0] MEM_RegDst,
    input  logic             MEM_Access,
    input  logic             MEM_Ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FreezeCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    hazState_e        state;
    logic [CNT_W-1:0] waitCnt;
    logic             luHit;
    logic             beHit;
    logic             bmHit;
    logic             freeze;
    logic             stallHit;
    logic             stall;
    logic             flush;
    pipeCtrl_t        ctrl;

    hazard_cmp #(.REG_W(REG_W)) u_cmpLu (
        .en(EX_MemRead), .dst(EX_RegDst), .rs(ID_RegRs), .rt(ID_RegRt),
        .usesRt(ID_UsesRt), .hit_c(luHit)
    );

    hazard_cmp #(.REG_W(REG_W)) u_cmpBe (
        .en(ID_Branch && EX_RegWrite), .dst(EX_RegDst), .rs(ID_RegRs), .rt(ID_RegRt),
        .usesRt(ID_UsesRt), .hit_c(beHit)
    );

    hazard_cmp #(.REG_W(REG_W)) u_cmpBm (
        .en(ID_Branch && MEM_MemRead), .dst(MEM_RegDst), .rs(ID_RegRs), .rt(ID_RegRt),
        .usesRt(ID_UsesRt), .hit_c(bmHit)
    );

    // Freeze starts in the very cycle a not-ready access appears, before WAIT is entered.
    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:     freeze = MEM_Access && !MEM_Ready;
            WAIT:    freeze = !MEM_Ready;
            ERR:     freeze = 1'b1;
            default: freeze = 1'b1;
        endcase
    end

    assign stallHit = luHit || beHit || bmHit;
    assign stall    = !freeze && stallHit;
    assign flush    = !freeze && !stallHit && (ID_BranchTaken || ID_Jump);

    always_comb begin
        ctrl = CTRL_FLOW;
        if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (stall) begin
            ctrl.pcWrite    = 1'b0;
            ctrl.ifidWrite  = 1'b0;
            ctrl.idexBubble = 1'b1;
        end else if (flush) begin
            ctrl.ifidFlush  = 1'b1;
        end
    end

    assign PCWrite      = ctrl.pcWrite;
    assign IFID_Write   = ctrl.ifidWrite;
    assign IFID_Flush   = ctrl.ifidFlush;
    assign IDEX_Write   = ctrl.idexWrite;
    assign IDEX_Bubble  = ctrl.idexBubble;
    assign EXMEM_Write  = ctrl.exmemWrite;
    assign MEMWB_Bubble = ctrl.memwbBubble;
    assign MemErr       = (state == ERR);

    // waitCnt counts not-ready cycles of the current access; the trap fires on the MEM_TIMEOUT-th.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (MEM_Access && !MEM_Ready) begin
                        state   <= WAIT;
                        waitCnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (MEM_Ready) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt >= CNT_W'(MEM_TIMEOUT - 1)) begin
                        state   <= ERR;
                        waitCnt <= CNT_W'(MEM_TIMEOUT);
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCnt  <= '0;
            FreezeCnt <= '0;
            FlushCnt  <= '0;
        end else begin
            if (stall && (StallCnt != '1))
                StallCnt <= StallCnt + CNT_W'(1);
            if (freeze && (FreezeCnt != '1))
                FreezeCnt <= FreezeCnt + CNT_W'(1);
            if (flush && (FlushCnt != '1))
                FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios plus random traffic
// against a cycle-count reference model; HAZARD_PERF_EN also checks the counters.
module tb_hazard_unit;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [REG_W-1:0] ID_RegRs, ID_RegRt, EX_RegDst, MEM_RegDst;
    logic             ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
    logic             EX_MemRead, EX_RegWrite, MEM_MemRead, MEM_Access, MEM_Ready;
    logic             PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble;
    logic             EXMEM_Write, MEMWB_Bubble, MemErr;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] StallCnt, FreezeCnt, FlushCnt;
`endif

    hazard_unit #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RegDst(EX_RegDst),
        .MEM_MemRead(MEM_MemRead), .MEM_RegDst(MEM_RegDst),
        .MEM_Access(MEM_Access), .MEM_Ready(MEM_Ready),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Write(EXMEM_Write),
        .MEMWB_Bubble(MEMWB_Bubble), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt), .FreezeCnt(FreezeCnt), .FlushCnt(FlushCnt)
`endif
    );

    typedef struct {
        int       cyc;
        logic [7:0] ctrl;
        int       stallC;
        int       freezeC;
        int       flushC;
    } exp_t;

    exp_t q[$];
    int   nCmp = 0;
    int   nBad = 0;
    int   cycNo = 0;

    // Reference model: pending-access flag, consecutive not-ready count, trap flag, event tallies.
    bit mWait, mErr;
    int mNotReady, mStall, mFreeze, mFlush;

    function automatic bit readsReg(logic [REG_W-1:0] d, logic [REG_W-1:0] rs,
                                    logic [REG_W-1:0] rt, logic usesRt);
        return (d != 0) && ((d == rs) || (usesRt && (d == rt)));
    endfunction

    function automatic int sat(int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic setIdle();
        ID_RegRs = '0; ID_RegRt = '0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
        ID_BranchTaken = 1'b0; ID_Jump = 1'b0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
        EX_RegDst = '0; MEM_MemRead = 1'b0; MEM_RegDst = '0; MEM_Access = 1'b0;
        MEM_Ready = 1'b1; rst_n = 1'b1;
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, then clock the model.
    task automatic step();
        exp_t e;
        bit frz, hz, stl, fls;
        frz = mErr || ((mWait || MEM_Access) && !MEM_Ready);
        hz  = (EX_MemRead && readsReg(EX_RegDst, ID_RegRs, ID_RegRt, ID_UsesRt))
           || (ID_Branch && EX_RegWrite && readsReg(EX_RegDst, ID_RegRs, ID_RegRt, ID_UsesRt))
           || (ID_Branch && MEM_MemRead && readsReg(MEM_RegDst, ID_RegRs, ID_RegRt, ID_UsesRt));
        stl = !frz && hz;
        fls = !frz && !hz && (ID_BranchTaken || ID_Jump);
        e.cyc     = cycNo;
        e.ctrl    = {!frz && !stl, !frz && !stl, fls, !frz, stl, !frz, frz, mErr};
        e.stallC  = mStall;
        e.freezeC = mFreeze;
        e.flushC  = mFlush;
        q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            mWait = 0; mErr = 0; mNotReady = 0; mStall = 0; mFreeze = 0; mFlush = 0;
        end else begin
            if (stl) mStall = sat(mStall);
            if (frz) mFreeze = sat(mFreeze);
            if (fls) mFlush = sat(mFlush);
            if (!mErr) begin
                if (frz) begin
                    mNotReady++;
                    if (mNotReady >= MEM_TIMEOUT) mErr = 1;
                    else mWait = 1;
                end else begin
                    mWait = 0;
                    mNotReady = 0;
                end
            end
        end
        #1;
        cycNo++;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = q.pop_front();
            act = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
                   EXMEM_Write, MEMWB_Bubble, MemErr};
            nCmp++;
            if (act !== e.ctrl) begin
                nBad++;
                $display("FAIL ctrl cyc=%0d got=%b want=%b (PCW IFW IFF IDW IDB EMW MWB ERR)",
                         e.cyc, act, e.ctrl);
            end
`ifdef HAZARD_PERF_EN
            nCmp++;
            if (StallCnt !== CNT_W'(e.stallC) || FreezeCnt !== CNT_W'(e.freezeC)
                || FlushCnt !== CNT_W'(e.flushC)) begin
                nBad++;
                $display("FAIL perf cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", e.cyc,
                         StallCnt, FreezeCnt, FlushCnt, e.stallC, e.freezeC, e.flushC);
            end
`endif
        end
    end

    initial begin
        setIdle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mWait = 0; mErr = 0; mNotReady = 0; mStall = 0; mFreeze = 0; mFlush = 0;
        rst_n = 1'b1;

        // Reset state with idle inputs.
        repeat (2) step();

        // lw $2 in EX, add rs=2 in ID: one stall then flow.
        EX_MemRead = 1; EX_RegWrite = 1; EX_RegDst = 5'd2; ID_RegRs = 5'd2; ID_RegRt = 5'd7;
        ID_UsesRt = 1; step();
        setIdle(); ID_RegRs = 5'd2; step();
        setIdle(); step();

        // lw $3 then beq rs=3: LU, then BM, then resolved taken branch flushes.
        EX_MemRead = 1; EX_RegWrite = 1; EX_RegDst = 5'd3;
        ID_Branch = 1; ID_RegRs = 5'd3; ID_RegRt = 5'd4; ID_UsesRt = 1; ID_BranchTaken = 1;
        step();
        EX_MemRead = 0; EX_RegWrite = 0; EX_RegDst = 5'd0; MEM_MemRead = 1; MEM_RegDst = 5'd3;
        step();
        MEM_MemRead = 0; MEM_RegDst = 5'd0; step();
        setIdle(); step();

        // Destination 0 never hazards, including via rt; a jump flushes.
        EX_MemRead = 1; EX_RegDst = 5'd0; ID_RegRs = 5'd0; ID_RegRt = 5'd0; ID_UsesRt = 1;
        step();
        setIdle(); ID_Jump = 1; step();
        setIdle(); EX_MemRead = 1; EX_RegDst = 5'd6; ID_RegRt = 5'd6; ID_UsesRt = 0; step();
        ID_UsesRt = 1; step();
        setIdle(); ID_Branch = 1; EX_RegWrite = 1; EX_RegDst = 5'd9; ID_RegRs = 5'd9; step();
        setIdle(); step();

        // Three not-ready cycles then ready.
        MEM_Access = 1; MEM_Ready = 0; repeat (3) step();
        MEM_Ready = 1; step();
        setIdle(); repeat (2) step();

        // Access held not-ready past the timeout, then one reset edge.
        MEM_Access = 1; MEM_Ready = 0; repeat (MEM_TIMEOUT + 4) step();
        MEM_Ready = 1; MEM_Access = 0; repeat (2) step();
        rst_n = 0; step();
        setIdle(); repeat (2) step();

        // Load-use coinciding with a not-ready access: freeze dominates.
        EX_MemRead = 1; EX_RegDst = 5'd5; ID_RegRs = 5'd5; MEM_Access = 1; MEM_Ready = 0;
        step();
        MEM_Ready = 1; step();
        setIdle(); step();

        // Reset in the middle of a wait abandons the access.
        MEM_Access = 1; MEM_Ready = 0; repeat (4) step();
        rst_n = 0; step();
        setIdle(); MEM_Ready = 0; step();
        setIdle(); step();

        // Randomized traffic over a small register set to provoke overlaps.
        for (int i = 0; i < 600; i++) begin
            ID_RegRs       = REG_W'($urandom_range(0, 3));
            ID_RegRt       = REG_W'($urandom_range(0, 3));
            ID_UsesRt      = 1'($urandom_range(0, 1));
            ID_Branch      = ($urandom_range(0, 2) == 0);
            ID_BranchTaken = ID_Branch && ($urandom_range(0, 1) == 1);
            ID_Jump        = ($urandom_range(0, 7) == 0);
            EX_MemRead     = ($urandom_range(0, 2) == 0);
            EX_RegWrite    = ($urandom_range(0, 1) == 1);
            EX_RegDst      = REG_W'($urandom_range(0, 3));
            MEM_MemRead    = ($urandom_range(0, 2) == 0);
            MEM_RegDst     = REG_W'($urandom_range(0, 3));
            MEM_Access     = ($urandom_range(0, 3) == 0);
            MEM_Ready      = ($urandom_range(0, 9) < 6);
            rst_n          = ($urandom_range(0, 149) != 0);
            step();
        end
        setIdle(); step();

        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            nBad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
